// File: rtl/oam_mwram.sv
// Mixed-width sprite attribute RAM: byte CPU port A, wide PPU read port B, even/odd write latch, clear sequencer.
// Latency A=1, B=1+OUT_REG; no backpressure, accesses are dropped while busy clears the array.
module oam_mwram #(
    parameter int          DEPTH_B    = 128,
    parameter int          RATIO      = 4,
    parameter int          LATCH_MODE = 1,
    parameter int          OUT_REG    = 0,
    parameter logic [7:0]  INIT_VAL   = 8'h00,
    localparam int         AW_B       = $clog2(DEPTH_B),
    localparam int         LW         = $clog2(RATIO),
    localparam int         AW_A       = AW_B + LW,
    localparam int         DW_B       = 8 * RATIO
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            init_req,
    output logic            busy,
    input  logic            a_we,
    input  logic            a_re,
    input  logic [AW_A-1:0] a_addr,
    input  logic [7:0]      a_wdata,
    output logic [7:0]      a_rdata,
    output logic            a_rvalid,
    input  logic            b_re,
    input  logic [AW_B-1:0] b_addr,
    output logic [DW_B-1:0] b_rdata,
    output logic            b_rvalid
);
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW_B-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]      r_latch, w_latch_nxt;
    logic            w_clr;
    logic [7:0]      r_mem [0:RATIO-1][0:DEPTH_B-1];

    logic            w_a_we, w_a_re, w_b_re;
    logic [LW-1:0]   w_lane;
    logic [AW_B-1:0] w_row, w_wr_row;
    logic [RATIO-1:0] w_lane_we;
    logic [7:0]      w_lane_wdat [0:RATIO-1];
    logic [7:0]      w_a_rd;
    logic [DW_B-1:0] w_b_rd;

    logic [7:0]      r_a_rdata;
    logic            r_a_rvalid;
    logic [DW_B-1:0] r_b1_dat;
    logic            r_b1_vld;

    assign busy   = (r_state == S_CLEAR);
    assign w_a_we = a_we && (r_state == S_IDLE);
    assign w_a_re = a_re && (r_state == S_IDLE);
    assign w_b_re = b_re && (r_state == S_IDLE);
    assign w_lane = a_addr[LW-1:0];
    assign w_row  = a_addr[AW_A-1:LW];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch_nxt = r_latch;
        w_clr       = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr     = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == AW_B'(DEPTH_B - 1))
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (LATCH_MODE != 0 && w_a_we && !a_addr[0])
                    w_latch_nxt = a_wdata;
            end
        endcase
        // A restart wins over everything, including a same-cycle latch load.
        if (init_req) begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
            w_latch_nxt = '0;
        end
    end

    // Per-lane write enables: clear row, single byte, or odd commit of the byte pair.
    always_comb begin
        w_lane_we = '0;
        w_wr_row  = w_clr ? r_cnt : w_row;
        for (int k = 0; k < RATIO; k++) begin
            w_lane_wdat[k] = a_wdata;
            if (w_clr) begin
                w_lane_we[k]   = 1'b1;
                w_lane_wdat[k] = INIT_VAL;
            end else if (w_a_we) begin
                if (LW'(k) == w_lane) begin
                    if (LATCH_MODE == 0 || a_addr[0])
                        w_lane_we[k] = 1'b1;
                end else if (LATCH_MODE != 0 && a_addr[0] && ((LW'(k) ^ w_lane) == LW'(1))) begin
                    w_lane_we[k]   = 1'b1;
                    w_lane_wdat[k] = r_latch;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < RATIO; k++)
            if (w_lane_we[k])
                r_mem[k][w_wr_row] <= w_lane_wdat[k];
    end

    // Same-cycle writes are forwarded lane by lane so both ports see write-first data.
    always_comb begin
        w_a_rd = (w_lane_we[w_lane] && (w_wr_row == w_row)) ? w_lane_wdat[w_lane]
                                                             : r_mem[w_lane][w_row];
        w_b_rd = '0;
        for (int k = 0; k < RATIO; k++)
            w_b_rd[8*k +: 8] = (w_lane_we[k] && (w_wr_row == b_addr)) ? w_lane_wdat[k]
                                                                      : r_mem[k][b_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_latch    <= '0;
            r_a_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b1_dat   <= '0;
            r_b1_vld   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_latch    <= w_latch_nxt;
            r_a_rvalid <= w_a_re;
            r_b1_vld   <= w_b_re;
            if (w_a_re)
                r_a_rdata <= w_a_rd;
            if (w_b_re)
                r_b1_dat <= w_b_rd;
        end
    end

    assign a_rdata  = r_a_rdata;
    assign a_rvalid = r_a_rvalid;

    if (OUT_REG != 0) begin : g_oreg
        logic [DW_B-1:0] r_b2_dat;
        logic            r_b2_vld;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_b2_dat <= '0;
                r_b2_vld <= 1'b0;
            end else begin
                r_b2_vld <= r_b1_vld;
                if (r_b1_vld)
                    r_b2_dat <= r_b1_dat;
            end
        end
        assign b_rdata  = r_b2_dat;
        assign b_rvalid = r_b2_vld;
    end else begin : g_noreg
        assign b_rdata  = r_b1_dat;
        assign b_rvalid = r_b1_vld;
    end
endmodule

// File: doc/oam_mwram.md
# oam_mwram

Parametrised mixed-width dual-port RAM for sprite attribute memory. Byte-wide CPU port; wide PPU read port. Successor to the fixed 256x16 / 128x32 OAM macro: generalised width ratio and depth, plus an SNES-style even/odd write latch, a hardware clear sequencer, optional output register and same-cycle write-to-read forwarding. Sits between the PPU register interface (port A) and the sprite evaluation pipeline (port B).

## Interface
- DEPTH_B, 128: wide words; power of 2, ≥4.
- RATIO, 4: bytes per wide word; power of 2, ≥2.
- LATCH_MODE, 1: 1 = even byte writes go to latch, odd byte write commits the byte pair; 0 = direct byte writes.
- OUT_REG, 0: 1 adds a port-B output register (latency 2).
- INIT_VAL, 8'h00: byte value written by the clear sequencer.
- Derived: AW_B = clog2(DEPTH_B), AW_A = AW_B + clog2(RATIO), DW_B = 8*RATIO.

- clk  in  1  single clock for both ports.
- resetn  in  1  asynchronous, active-low reset.
- init_req  in  1  pulse: restart clear sequence.
- busy  out  1  high while clearing.
- a_we  in  1  byte write strobe.
- a_re  in  1  byte read strobe.
- a_addr  in  AW_A  byte address.
- a_wdata  in  8  write byte.
- a_rdata  out  8  read byte.
- a_rvalid  out  1  a_rdata valid pulse.
- b_re  in  1  wide read strobe.
- b_addr  in  AW_B  wide word address.
- b_rdata  out  DW_B  wide word, byte k = byte address b_addr*RATIO+k.
- b_rvalid  out  1  b_rdata valid pulse.

## Operation
- Storage: RATIO byte lanes, each DEPTH_B x 8; lane = a_addr[clog2(RATIO)-1:0], row = a_addr[AW_A-1:clog2(RATIO)].
- FSM states CLEAR, IDLE.
  - Reset → CLEAR, counter 0. CLEAR writes INIT_VAL to all lanes at row=counter, counter+1 per cycle; after row DEPTH_B-1 → IDLE. busy = (state==CLEAR).
  - init_req in any state → CLEAR, counter 0 (restart mid-clear); also clears latch.
  - In CLEAR all a_we/a_re/b_re are dropped; no valids.
- Port A write, LATCH_MODE=1: a_addr[0]=0 → latch <= a_wdata, memory untouched; a_addr[0]=1 → lane a_addr writes a_wdata and lane a_addr^1 writes latch, same cycle. Latch persists across commits (second odd write reuses it).
- Port A write, LATCH_MODE=0: single lane write.
- a_we and a_re same cycle: write happens; read returns new data (write-first).
- Port B read: one row, all lanes. Same-cycle port-A commit to that row: written lanes return new bytes, others old (per-lane forwarding).
- No port-B write path.

## Timing
- Reset values: a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, latch=0, busy=1 (first cycle after resetn rises and for DEPTH_B cycles total).
- Clear duration: exactly DEPTH_B cycles; busy falls the cycle after last row write; request accepted that cycle.
- Port A read latency 1: a_re at cycle n → a_rdata/a_rvalid at n+1.
- Port B read latency 1+OUT_REG; b_rvalid pulse aligned with data; b_rdata holds until next valid.
- Back-to-back reads every cycle on both ports; full throughput.
- Async reset mid-operation: outputs to reset values immediately, pending valids discarded, memory contents undefined until clear completes.
- Address wrap: none; full address range valid, no out-of-range case.

## Test plan
- Reset, DEPTH_B=128: busy high 128 cycles; then b_re each row → all 32'h00000000; b_re issued during busy → no b_rvalid.
- LATCH_MODE=1: write 8'hAA to addr 0x10, 8'hBB to 0x11 → b_re row 4 returns 32'h0000BBAA; write 0x10 only then read → unchanged.
- Forwarding: commit 8'h55/8'h66 to 0x22/0x23 same cycle as b_re row 8 (old 32'h11223344) → 32'h66553344.
- LATCH_MODE=0, OUT_REG=1: write 8'h7E to 0x1FF; a_re 0x1FF → 8'h7E at +1; b_re row 127 → byte3=8'h7E, b_rvalid at +2.
- init_req at clear cycle 50 → busy extends to 128 cycles after init_req; all rows INIT_VAL; latch reads as 0 on next odd commit.
- Assert resetn low mid-read → a_rvalid/b_rvalid 0 immediately, busy 1, clear restarts on release.
